psum_acc_ctrl: RTL

- Controller directly upstream of core's pmem and accumulator path; generates the pmem/ofifo/acc instruction fields that feed core's inst bus (bits 39:27 and 7).
- Phase 1 (drain): moves LEN_NIJ×LEN_KIJ raw psums from ofifo into pmem with psum_bypass set.
- Phase 2 (accumulate): reads the 9 kernel-shifted psums per output pixel with acc set, and flags when each accumulated output is on sfp_out.

---
 rtl/psum_acc_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/psum_acc_ctrl.sv
// Psum drain/accumulate controller: writes raw psums from ofifo into pmem, then reads
// kernel-shifted psum groups per output pixel and flags each accumulated output on sfp_out.
module psum_acc_ctrl #(
    parameter int unsigned LEN_NIJ = 36,
    parameter int unsigned LEN_KIJ = 9,
    parameter int unsigned IN_W    = 6,
    parameter int unsigned OUT_W   = 4,
    parameter int unsigned KER     = 3,
    parameter int unsigned A_W     = 9,
    parameter int unsigned ACC_LAT = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           ofifo_valid,
    output logic           ofifo_rd,
    output logic           cen_pmem,
    output logic           wen_pmem,
    output logic [A_W-1:0] a_pmem,
    output logic           acc,
    output logic           psum_bypass,
    output logic           out_valid,
    output logic [3:0]     out_idx,
    output logic           busy,
    output logic           done
);

    localparam int unsigned KW = (KER > 1) ? $clog2(KER) : 1;
    localparam int unsigned OW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [A_W-1:0] LastWr  = A_W'(LEN_NIJ * LEN_KIJ - 1);
    localparam logic [A_W-1:0] StepCol = A_W'(LEN_NIJ + 1);
    localparam logic [A_W-1:0] StepRow = A_W'(LEN_NIJ + IN_W - KER + 1);
    localparam logic [A_W-1:0] IcRow   = A_W'(IN_W - OUT_W + 1);

    typedef enum logic [2:0] {
        StIdle, StDrain, StAccum, StSep, StFlush, StDone
    } state_e;

    state_e         state_q, state_d;
    logic [A_W-1:0] addr_q, addr_d;
    logic [A_W-1:0] ic_q, ic_d, ic_nxt;
    logic [OW-1:0]  ocol_q, ocol_d;
    logic [3:0]     oc_q, oc_d;
    logic [KW-1:0]  kr_q, kr_d, kc_q, kc_d;
    logic           bypass_q;
    logic           load;
    logic [ACC_LAT-1:0] pipe_q, pipe_d, pend;
    logic [3:0]     idx_q [ACC_LAT];
    logic [3:0]     idx_d [ACC_LAT];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ic_d     = ic_q;
        ic_nxt   = ic_q;
        ocol_d   = ocol_q;
        oc_d     = oc_q;
        kr_d     = kr_q;
        kc_d     = kc_q;
        ofifo_rd = 1'b0;
        cen_pmem = 1'b1;
        wen_pmem = 1'b1;
        acc      = 1'b0;
        load     = 1'b0;
        pend     = pipe_q;
        pend[ACC_LAT-1] = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrain;
                    addr_d  = '0;
                end
            end
            StDrain: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    cen_pmem = 1'b0;
                    wen_pmem = 1'b0;
                    if (addr_q == LastWr) begin
                        state_d = StAccum;
                        addr_d  = '0;
                        ic_d    = '0;
                        ocol_d  = '0;
                        oc_d    = '0;
                        kr_d    = '0;
                        kc_d    = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StAccum: begin
                cen_pmem = 1'b0;
                acc      = 1'b1;
                // Column step skips one pixel; row step also jumps the (KER-1)-wide margin.
                if (kc_q == KW'(KER - 1)) begin
                    kc_d = '0;
                    if (kr_q == KW'(KER - 1)) begin
                        kr_d    = '0;
                        state_d = StSep;
                    end else begin
                        kr_d   = kr_q + 1'b1;
                        addr_d = addr_q + StepRow;
                    end
                end else begin
                    kc_d   = kc_q + 1'b1;
                    addr_d = addr_q + StepCol;
                end
            end
            StSep: begin
                load = 1'b1;
                if (oc_q == 4'(OUT_W * OUT_W - 1)) begin
                    state_d = StFlush;
                end else begin
                    state_d = StAccum;
                    oc_d    = oc_q + 1'b1;
                    if (ocol_q == OW'(OUT_W - 1)) begin
                        ocol_d = '0;
                        ic_nxt = ic_q + IcRow;
                    end else begin
                        ocol_d = ocol_q + 1'b1;
                        ic_nxt = ic_q + 1'b1;
                    end
                    ic_d   = ic_nxt;
                    addr_d = ic_nxt;
                end
            end
            StFlush: begin
                // Leave once only the entry now on the output stage remains.
                if (pend == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                addr_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = load;
        idx_d[0]  = oc_q;
        for (int i = 1; i < int'(ACC_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
            idx_d[i]  = idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            ic_q     <= '0;
            ocol_q   <= '0;
            oc_q     <= '0;
            kr_q     <= '0;
            kc_q     <= '0;
            bypass_q <= 1'b0;
            pipe_q   <= '0;
            for (int i = 0; i < int'(ACC_LAT); i++) idx_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ic_q     <= ic_d;
            ocol_q   <= ocol_d;
            oc_q     <= oc_d;
            kr_q     <= kr_d;
            kc_q     <= kc_d;
            bypass_q <= (state_d == StDrain);
            pipe_q   <= pipe_d;
            for (int i = 0; i < int'(ACC_LAT); i++) idx_q[i] <= idx_d[i];
        end
    end

    assign a_pmem      = addr_q;
    assign psum_bypass = bypass_q;
    assign out_valid   = pipe_q[ACC_LAT-1];
    assign out_idx     = idx_q[ACC_LAT-1];
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule
